// File: rtl/alu_pkg.sv
// Shared ALU control codes and arbiter FSM state encodings.
package alu_pkg;

    typedef enum logic [3:0] {
        ALU_AND  = 4'b0000,
        ALU_OR   = 4'b0001,
        ALU_ADD  = 4'b0010,
        ALU_SLL1 = 4'b0100,
        ALU_SUB  = 4'b0110,
        ALU_SLTU = 4'b0111
    } alu_ctrl_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } arb_state_e;

endpackage

// File: rtl/ALU.sv
// Purely combinational ALU; zero latency, no flow control.
// Unlisted control codes produce a zero result.
module ALU
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [3:0]      ctrl,
    output logic [XLEN-1:0] result
);

    always_comb begin
        result = '0;
        case (ctrl)
            ALU_AND:  result = a & b;
            ALU_OR:   result = a | b;
            ALU_ADD:  result = a + b;
            ALU_SUB:  result = a - b;
            ALU_SLTU: result = {{(XLEN-1){1'b0}}, (a < b)};
            ALU_SLL1: result = {a[XLEN-2:0], 1'b0};
            default:  result = '0;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// Two requesters share one ALU via round-robin; result registered 1 cycle after accept.
// Backpressure: while a response is held and rsp_ready is low, both req ready outputs stay 0.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [XLEN-1:0]  req0_a,
    input  logic [XLEN-1:0]  req0_b,
    input  logic [3:0]       req0_ctrl,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [XLEN-1:0]  req1_a,
    input  logic [XLEN-1:0]  req1_b,
    input  logic [3:0]       req1_ctrl,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [XLEN-1:0]  rsp_result,
    output logic             rsp_zero,
    output logic             rsp_id,
    output logic [CNT_W-1:0] op_count
);

    arb_state_e      state;
    logic            last_grant;
    logic            can_accept;
    logic            grant0;
    logic            grant1;
    logic            any_grant;
    logic [XLEN-1:0] alu_a;
    logic [XLEN-1:0] alu_b;
    logic [3:0]      alu_ctrl;
    logic [XLEN-1:0] alu_res;

    // Grant logic looks only at valids and state, never at operands or ctrl.
    assign can_accept = !reset && ((state == ST_IDLE) || rsp_ready);
    assign grant0     = can_accept && req0_valid && (!req1_valid || last_grant);
    assign grant1     = can_accept && req1_valid && (!req0_valid || !last_grant);
    assign any_grant  = grant0 || grant1;

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    assign alu_a    = grant1 ? req1_a    : req0_a;
    assign alu_b    = grant1 ? req1_b    : req0_b;
    assign alu_ctrl = grant1 ? req1_ctrl : req0_ctrl;

    ALU #(
        .XLEN(XLEN)
    ) u_alu (
        .a      (alu_a),
        .b      (alu_b),
        .ctrl   (alu_ctrl),
        .result (alu_res)
    );

    assign rsp_valid = (state == ST_HOLD);

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            last_grant <= 1'b1;
            rsp_result <= '0;
            rsp_zero   <= 1'b0;
            rsp_id     <= 1'b0;
            op_count   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (any_grant) begin
                        state <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (rsp_ready && !any_grant) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase

            if (any_grant) begin
                rsp_result <= alu_res;
                rsp_zero   <= (alu_res == '0);
                rsp_id     <= grant1;
                last_grant <= grant1;
                op_count   <= op_count + CNT_W'(1);
            end
        end
    end

endmodule
